// File: rtl/conv_pkg.sv
// Shared constants and FSM state type for the convolutional-encoder frame feeder.
package conv_pkg;

   localparam int unsigned EncDepth = 3;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StTail
   } feed_state_e;

endpackage

// File: rtl/conv_frame_feeder.sv
// Serialises DATA_W-bit beats MSB first into the encoder's b0 input and appends
// TAIL_LEN zero bits per frame so the encoder returns to the all-zero state.
module conv_frame_feeder
   import conv_pkg::*;
#(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned TAIL_LEN = EncDepth
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   output logic              enc_bit,
   output logic              bit_valid,
   output logic              frame_start,
   output logic              tail_active,
   output logic              frame_done,
   output logic              err_underrun
);

   localparam int unsigned CntW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int unsigned TailW = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;
   localparam logic [CntW-1:0]  LastBit  = CntW'(DATA_W - 1);
   localparam logic [TailW-1:0] LastTail = TailW'(TAIL_LEN - 1);

   feed_state_e       state_q;
   logic [DATA_W-1:0] shreg_q;
   logic [CntW-1:0]   cnt_q;
   logic [TailW-1:0]  tail_cnt_q;
   logic              last_q;
   logic              enc_bit_q;
   logic              bit_valid_q;
   logic              frame_start_q;
   logic              tail_active_q;
   logic              frame_done_q;
   logic              err_underrun_q;
   logic              xfer;

   // cnt_q indexes the bit loaded into enc_bit_q at the coming edge, so the
   // next beat is accepted one cycle ahead and follows with no gap.
   assign in_ready = (state_q == StIdle) ||
                     ((state_q == StShift) && (cnt_q == LastBit) && !last_q);
   assign xfer     = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= StIdle;
         shreg_q        <= '0;
         cnt_q          <= '0;
         tail_cnt_q     <= '0;
         last_q         <= 1'b0;
         enc_bit_q      <= 1'b0;
         bit_valid_q    <= 1'b0;
         frame_start_q  <= 1'b0;
         tail_active_q  <= 1'b0;
         frame_done_q   <= 1'b0;
         err_underrun_q <= 1'b0;
      end else begin
         frame_start_q  <= 1'b0;
         frame_done_q   <= 1'b0;
         err_underrun_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               enc_bit_q     <= 1'b0;
               bit_valid_q   <= 1'b0;
               tail_active_q <= 1'b0;
               if (xfer) begin
                  // MSB goes straight out so the first bit lands one cycle after the transfer
                  enc_bit_q     <= in_data[DATA_W-1];
                  shreg_q       <= in_data << 1;
                  last_q        <= in_last;
                  cnt_q         <= CntW'(1);
                  bit_valid_q   <= 1'b1;
                  frame_start_q <= 1'b1;
                  state_q       <= StShift;
               end
            end
            StShift: begin
               enc_bit_q   <= shreg_q[DATA_W-1];
               bit_valid_q <= 1'b1;
               shreg_q     <= shreg_q << 1;
               cnt_q       <= cnt_q + 1'b1;
               if (cnt_q == LastBit) begin
                  if (last_q) begin
                     tail_cnt_q <= '0;
                     state_q    <= StTail;
                  end else if (xfer) begin
                     shreg_q <= in_data;
                     last_q  <= in_last;
                     cnt_q   <= '0;
                  end else begin
                     err_underrun_q <= 1'b1;
                     tail_cnt_q     <= '0;
                     state_q        <= StTail;
                  end
               end
            end
            StTail: begin
               enc_bit_q <= 1'b0;
               if (frame_done_q) begin
                  bit_valid_q   <= 1'b0;
                  tail_active_q <= 1'b0;
                  state_q       <= StIdle;
               end else begin
                  bit_valid_q   <= 1'b1;
                  tail_active_q <= 1'b1;
                  tail_cnt_q    <= tail_cnt_q + 1'b1;
                  frame_done_q  <= (tail_cnt_q == LastTail);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign enc_bit      = enc_bit_q;
   assign bit_valid    = bit_valid_q;
   assign frame_start  = frame_start_q;
   assign tail_active  = tail_active_q;
   assign frame_done   = frame_done_q;
   assign err_underrun = err_underrun_q;

endmodule

// File: tb/tb_conv_frame_feeder.sv
// Directed scoreboard bench for conv_frame_feeder with a reference depth-3 encoder.
module tb_conv_frame_feeder;
   import conv_pkg::*;

   localparam int unsigned DW = 8;
   localparam int unsigned TL = EncDepth;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_last;
   logic          in_ready;
   logic          enc_bit;
   logic          bit_valid;
   logic          frame_start;
   logic          tail_active;
   logic          frame_done;
   logic          err_underrun;

   always #5 clk = ~clk;

   conv_frame_feeder #(
      .DATA_W   (DW),
      .TAIL_LEN (TL)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_last      (in_last),
      .in_ready     (in_ready),
      .enc_bit      (enc_bit),
      .bit_valid    (bit_valid),
      .frame_start  (frame_start),
      .tail_active  (tail_active),
      .frame_done   (frame_done),
      .err_underrun (err_underrun)
   );

   // Reference encoder: c0 = s0^s2, c1 = s0^s1^s2 over the last three b0 bits
   logic [2:0] enc_s;
   logic [1:0] enc_c;
   always_ff @(posedge clk) begin
      if (reset) enc_s <= '0;
      else       enc_s <= {enc_s[1:0], enc_bit};
   end
   assign enc_c = {enc_s[0] ^ enc_s[2], enc_s[0] ^ enc_s[1] ^ enc_s[2]};

   // out = {enc_bit, bit_valid, frame_start, tail_active, frame_done, err_underrun}
   typedef struct packed {
      logic [5:0] out;
      logic       rdy;
      logic       chk_rdy;
   } exp_t;

   exp_t          q[$];
   int            checks = 0;
   int            failures = 0;
   string         tag;
   logic [DW-1:0] cur_data;
   logic          cur_last, cur_start, cur_nonext;
   logic          mon_en;
   logic          xfer_seen;

   task automatic check_val(input string what, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s/%s observed=%0h expected=%0h", tag, what, obs, exp);
      end
   endtask

   task automatic push_beat();
      exp_t e;
      for (int i = DW - 1; i >= 0; i--) begin
         e.out = {cur_data[i], 1'b1, cur_start && (i == DW - 1), 1'b0, 1'b0,
                  cur_nonext && !cur_last && (i == 0)};
         e.rdy = 1'b0;
         e.chk_rdy = (i >= 2) || ((i == 0) && cur_last);
         q.push_back(e);
      end
      if (cur_last || cur_nonext) begin
         for (int k = 0; k < TL; k++) begin
            e.out = {1'b0, 1'b1, 1'b0, 1'b1, (k == TL - 1), 1'b0};
            e.rdy = 1'b0;
            e.chk_rdy = 1'b1;
            q.push_back(e);
         end
      end
   endtask

   // One clock: compare outputs at the falling edge, then record any transfer.
   task automatic step();
      exp_t e;
      logic xfer;
      @(negedge clk);
      xfer = in_valid && in_ready;
      if (mon_en) begin
         if (q.size() != 0) e = q.pop_front();
         else               e = '{out: 6'b0, rdy: 1'b1, chk_rdy: 1'b1};
         check_val("outputs", {26'd0, enc_bit, bit_valid, frame_start, tail_active,
                               frame_done, err_underrun}, {26'd0, e.out});
         if (e.chk_rdy) check_val("in_ready", {31'd0, in_ready}, {31'd0, e.rdy});
      end
      @(posedge clk);
      #1;
      if (reset) begin
         q.delete();
      end else if (xfer) begin
         push_beat();
         in_valid  = 1'b0;
         xfer_seen = 1'b1;
      end
   endtask

   task automatic drive_beat(input logic [DW-1:0] d, input logic last, input logic start,
                             input logic nonext);
      cur_data   = d;
      cur_last   = last;
      cur_start  = start;
      cur_nonext = nonext;
      in_data    = d;
      in_last    = last;
      in_valid   = 1'b1;
   endtask

   task automatic wait_xfer(input int budget, output int n);
      n = 0;
      xfer_seen = 1'b0;
      while (!xfer_seen && n < budget) begin
         step();
         n++;
      end
      check_val("xfer_seen", {31'd0, xfer_seen}, 32'd1);
   endtask

   initial begin
      int n;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
      mon_en   = 1'b0;
      tag      = "reset";
      repeat (3) @(posedge clk);
      #1;
      reset  = 1'b0;
      mon_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = DW'($urandom);
         in_last = 1'($urandom);
         step();
      end

      tag = "single_a5";
      drive_beat(8'hA5, 1'b1, 1'b1, 1'b0);
      wait_xfer(4, n);
      check_val("idle_accept_cycles", n, 32'd1);
      repeat (14) step();

      tag = "back_to_back";
      drive_beat(8'hFF, 1'b0, 1'b1, 1'b0);
      wait_xfer(4, n);
      drive_beat(8'h00, 1'b1, 1'b0, 1'b0);
      wait_xfer(12, n);
      repeat (14) step();

      tag = "underrun";
      drive_beat(8'h81, 1'b0, 1'b1, 1'b1);
      wait_xfer(4, n);
      repeat (14) step();

      tag = "reset_mid";
      drive_beat(8'hF0, 1'b1, 1'b1, 1'b0);
      wait_xfer(4, n);
      repeat (4) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      repeat (10) step();

      tag = "encoder";
      drive_beat(8'h80, 1'b1, 1'b1, 1'b0);
      wait_xfer(4, n);
      step();
      check_val("c0c1_1", {30'd0, enc_c}, 32'h3);
      step();
      check_val("c0c1_2", {30'd0, enc_c}, 32'h1);
      step();
      check_val("c0c1_3", {30'd0, enc_c}, 32'h3);
      for (int i = 0; i < 9; i++) begin
         step();
         check_val("c0c1_flush", {30'd0, enc_c}, 32'h0);
      end
      check_val("enc_state", {29'd0, enc_s}, 32'h0);

      tag = "hold_in_tail";
      drive_beat(8'hA5, 1'b1, 1'b1, 1'b0);
      wait_xfer(4, n);
      drive_beat(8'h3C, 1'b1, 1'b1, 1'b0);
      wait_xfer(20, n);
      check_val("held_beat_cycles", n, 32'd12);
      repeat (14) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/conv_frame_feeder.md
CONV_FRAME_FEEDER -- requirements
Module: conv_frame_feeder

Interface
REQ-001 Parameter DATA_W, default 8: width of each input data beat in bits.
REQ-002 Parameter TAIL_LEN, default 3: number of zero tail bits appended per frame; equals the encoder shift-register depth.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_data  input  DATA_W  data beat, transmitted MSB first.
REQ-006 in_valid  input  1  in_data/in_last valid.
REQ-007 in_last  input  1  current beat is the final beat of the frame.
REQ-008 in_ready  output  1  feeder accepts the beat this cycle.
REQ-009 enc_bit  output  1  serial bit driving the encoder's b0 input.
REQ-010 bit_valid  output  1  enc_bit is part of a frame (data or tail).
REQ-011 frame_start  output  1  enc_bit is the first bit of a frame.
REQ-012 tail_active  output  1  enc_bit is a tail bit.
REQ-013 frame_done  output  1  one-cycle pulse on the final tail bit.
REQ-014 err_underrun  output  1  one-cycle pulse when a frame is terminated by input starvation.

Function
REQ-015 The beat transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; otherwise the beat is not consumed.
REQ-016 The FSM SHALL have the states IDLE, SHIFT and TAIL.
REQ-017 IDLE: in_ready=1, enc_bit=0, bit_valid=0; on transfer, load the shift register and in_last, clear the bit counter, go to SHIFT.
REQ-018 enc_bit, bit_valid, frame_start, tail_active, frame_done and err_underrun SHALL be registered; the first bit of an accepted beat SHALL appear on the cycle after the transfer (latency 1).
REQ-019 SHIFT: output shreg[DATA_W-1] with bit_valid=1, shift left by 1 each cycle; the bit counter is clog2(DATA_W) bits wide and counts 0..DATA_W-1.
REQ-020 in_ready SHALL be 1 in SHIFT only on bit DATA_W-1 of a beat whose latched last flag is 0; it SHALL be 0 in all other SHIFT cycles and in TAIL.
REQ-021 On bit DATA_W-1 with last=0 and a transfer: load the next beat and stay in SHIFT, with no gap cycle between beats.
REQ-022 On bit DATA_W-1 with last=0 and no transfer: pulse err_underrun in that output cycle, then go to TAIL.
REQ-023 On bit DATA_W-1 with last=1: go to TAIL.
REQ-024 TAIL: output enc_bit=0, bit_valid=1, tail_active=1 for exactly TAIL_LEN cycles; frame_done=1 on the last of them; then go to IDLE.
REQ-025 frame_start SHALL be 1 only on the first data bit following IDLE.
REQ-026 An in_valid beat that is not accepted SHALL be held by upstream; in_data and in_last SHALL NOT be sampled outside a transfer.

Reset
REQ-027 While reset=1 at a clock edge: state goes to IDLE and shift register, counters and all registered outputs go to 0; in_ready reads 1 from the following cycle.
REQ-028 A reset in SHIFT or TAIL SHALL discard the in-flight frame; frame_done and err_underrun SHALL NOT pulse for it.

Structure
REQ-029 The shared package conv_pkg SHALL hold the FSM state enum and the encoder depth constant (3), which is the default for TAIL_LEN.
REQ-030 The block SHALL be a single module with no sub-module; the shift register and counters are inline.

Verification
REQ-031 Single beat 0xA5, in_last=1, transferred at cycle 0 -> enc_bit is 1,0,1,0,0,1,0,1 on cycles 1-8 with frame_start on cycle 1; 0,0,0 on cycles 9-11 with tail_active=1; frame_done on cycle 11; in_ready=1 again on cycle 12.
REQ-032 Back-to-back beats 0xFF (last=0) and 0x00 (last=1) -> 16 contiguous bit_valid cycles with no gap, second transfer on bit 7 of the first beat, then 3 tail cycles.
REQ-033 Beat 0x81 (last=0) with in_valid low afterwards -> err_underrun on bit 7 output cycle, 3 tail bits, frame_done, return to IDLE.
REQ-034 Reset asserted during bit 4 of 0xF0 -> next cycle all outputs 0 and in_ready=1; no frame_done or err_underrun for the aborted frame.
REQ-035 Feeder driving the encoder with beat 0x80, in_last=1 -> encoder (c0,c1) pairs 11,01,11 on the three cycles after the 1 enters, then 00 thereafter, confirming the tail returns the encoder to the zero state.
REQ-036 in_valid held high while in_ready=0 during TAIL -> the beat is not consumed until IDLE, then sent intact as a new frame with frame_start.
